// File: rtl/key_exp_inv_pkg.sv
// key_exp_inv_pkg: shared AES-128 constants, Rcon table and FSM state type.
package key_exp_inv_pkg;

   localparam int AES128_ROUNDS = 10;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Indexed by round number; entries outside 1..10 are never used.
   localparam logic [7:0] RCON [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   function automatic logic [7:0] rcon(input logic [3:0] i);
      return RCON[i];
   endfunction

endpackage

// File: rtl/key_exp_inv_sbox.sv
// key_exp_inv_sbox: forward AES S-box, one byte, purely combinational.
module key_exp_inv_sbox (
   input  logic [7:0] addr,
   output logic [7:0] dout
);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the top byte, so the bit offset is 8*(255-addr).
   assign dout = SBOX[{~addr, 3'b000} +: 8];

endmodule

// File: rtl/key_exp_inv.sv
// key_exp_inv: walks the AES-128 key schedule backwards from the round-10 key,
// presenting one round key per valid/ready transfer, rounds 10 down to 0.
module key_exp_inv
   import key_exp_inv_pkg::*;
#(
   parameter int ROUNDS = AES128_ROUNDS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] last_key,
   output logic         busy,
   output logic         key_valid,
   input  logic         key_ready,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         done
);

   state_t       state;
   logic [31:0]  p0, p1, p2, p3, rot, sub;
   logic [127:0] next_key;

   assign p3  = round_key[31:0] ^ round_key[63:32];
   assign p2  = round_key[63:32] ^ round_key[95:64];
   assign p1  = round_key[95:64] ^ round_key[127:96];
   assign rot = {p3[23:0], p3[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_sb
      key_exp_inv_sbox u_sb (.addr(rot[8*b +: 8]), .dout(sub[8*b +: 8]));
   end

   // Recovering w0 of the previous round needs its w3, which is p3.
   assign p0       = round_key[127:96] ^ sub ^ {rcon(round_idx), 24'h0};
   assign next_key = {p0, p1, p2, p3};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         key_valid <= 1'b0;
         done      <= 1'b0;
         round_key <= '0;
         round_idx <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state     <= RUN;
               busy      <= 1'b1;
               key_valid <= 1'b1;
               round_key <= last_key;
               round_idx <= 4'(ROUNDS);
            end
            RUN: if (key_ready) begin
               if (round_idx == 4'd0) begin
                  state     <= DONE;
                  key_valid <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  round_key <= next_key;
                  round_idx <= round_idx - 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_exp_inv.sv
// tb_key_exp_inv: scoreboard bench for key_exp_inv; expected keys come from an
// independent forward key expansion with an S-box derived from GF(2^8) inverses.
module tb_key_exp_inv;

   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] OTHER    = 128'h00112233445566778899aabbccddeeff;

   typedef struct packed {
      logic [3:0]   idx;
      logic [127:0] key;
   } exp_t;

   logic         clk, rst, start, key_ready, busy, key_valid, done;
   logic [127:0] last_key, round_key;
   logic [3:0]   round_idx;

   int           checks = 0;
   int           errors = 0;
   exp_t         q[$];
   exp_t         e;
   logic [7:0]   sb [256];
   logic [127:0] model_rk [11];

   key_exp_inv dut (
      .clk(clk), .rst(rst), .start(start), .last_key(last_key),
      .busy(busy), .key_valid(key_valid), .key_ready(key_ready),
      .round_key(round_key), .round_idx(round_idx), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p ^= a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] x);
      return {x[6:0], x[7]};
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sb[a] = inv ^ rl(inv) ^ rl(rl(inv)) ^ rl(rl(rl(inv))) ^ rl(rl(rl(rl(inv)))) ^ 8'h63;
      end
   endtask

   task automatic expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic push_seq();
      for (int r = 10; r >= 0; r--) q.push_back('{idx: 4'(r), key: model_rk[r]});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench one step after the edge that accepted start.
   task automatic do_start(input logic [127:0] k);
      tick();
      start    = 1'b1;
      last_key = k;
      tick();
      start = 1'b0;
   endtask

   // Returns at the falling edge inside the done cycle; lat>0 checks its position.
   task automatic wait_done(input int lat, input bit rnd);
      int n = 0;
      forever begin
         n++;
         @(negedge clk);
         if (done || n >= 1000) break;
         tick();
         if (rnd) key_ready = 1'($urandom_range(0, 1));
      end
      check("done_seen", {127'b0, done}, 128'd1);
      if (lat > 0) check("done_latency", 128'(n), 128'(lat));
      check("done_idx_hold", {124'b0, round_idx}, 128'd0);
   endtask

   task automatic after_done();
      tick();
      key_ready = 1'b1;
      @(negedge clk);
      check("done_pulse_one", {127'b0, done}, 128'd0);
      check("idle_busy", {127'b0, busy}, 128'd0);
      check("idle_valid", {127'b0, key_valid}, 128'd0);
      check("sb_drained", 128'(q.size()), 128'd0);
   endtask

   // Scoreboard monitor: a transfer will occur at the next rising edge.
   always @(negedge clk) begin
      if (!rst && key_valid && key_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key: got idx %0d key %h expected none", round_idx, round_key);
         end else begin
            e = q.pop_front();
            check("sb_idx", {124'b0, round_idx}, {124'b0, e.idx});
            check("sb_key", round_key, e.key);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      key_ready = 1'b1;
      last_key = '0;
      build_sbox();
      #1;
      check("rst_busy", {127'b0, busy}, 128'd0);
      check("rst_valid", {127'b0, key_valid}, 128'd0);
      check("rst_done", {127'b0, done}, 128'd0);
      check("rst_key", round_key, 128'd0);
      check("rst_idx", {124'b0, round_idx}, 128'd0);
      tick();
      rst = 1'b0;

      // FIPS-197 sequence with the consumer always ready.
      expand(FIPS_R0);
      check("model_r10", model_rk[10], FIPS_R10);
      check("model_r9", model_rk[9], FIPS_R9);
      push_seq();
      do_start(FIPS_R10);
      @(negedge clk);
      check("fips_r10", round_key, FIPS_R10);
      check("fips_idx10", {124'b0, round_idx}, 128'd10);
      tick();
      @(negedge clk);
      check("fips_r9", round_key, FIPS_R9);
      wait_done(10, 1'b0);
      check("fips_r0_hold", round_key, FIPS_R0);
      after_done();

      // Backpressure at round 9.
      push_seq();
      do_start(FIPS_R10);
      tick();
      key_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_idx", {124'b0, round_idx}, 128'd9);
         check("stall_key", round_key, FIPS_R9);
         tick();
      end
      key_ready = 1'b1;
      wait_done(0, 1'b0);
      after_done();

      // Start with another key while at round 5 must be ignored.
      push_seq();
      do_start(FIPS_R10);
      repeat (5) tick();
      @(negedge clk);
      check("busy_idx5", {124'b0, round_idx}, 128'd5);
      start    = 1'b1;
      last_key = OTHER;
      tick();
      start = 1'b0;
      wait_done(0, 1'b0);
      after_done();

      // Asynchronous reset at round 4, then a clean restart.
      push_seq();
      do_start(FIPS_R10);
      repeat (6) tick();
      @(negedge clk);
      check("pre_rst_idx4", {124'b0, round_idx}, 128'd4);
      rst = 1'b1;
      #1;
      check("async_busy", {127'b0, busy}, 128'd0);
      check("async_valid", {127'b0, key_valid}, 128'd0);
      check("async_key", round_key, 128'd0);
      check("async_idx", {124'b0, round_idx}, 128'd0);
      q.delete();
      tick();
      tick();
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_valid", {127'b0, key_valid}, 128'd0);
      end
      push_seq();
      do_start(FIPS_R10);
      wait_done(12, 1'b0);
      after_done();

      // Start held through DONE is taken only in the following IDLE cycle.
      push_seq();
      do_start(FIPS_R10);
      wait_done(12, 1'b0);
      start    = 1'b1;
      last_key = FIPS_R10;
      push_seq();
      tick();
      @(negedge clk);
      check("done_start_ignored", {127'b0, key_valid}, 128'd0);
      tick();
      start = 1'b0;
      @(negedge clk);
      check("idle_start_taken", {127'b0, key_valid}, 128'd1);
      check("idle_start_idx", {124'b0, round_idx}, 128'd10);
      wait_done(11, 1'b0);
      after_done();

      // Random keys with a randomly stalling consumer.
      for (int n = 0; n < 100; n++) begin
         expand({$urandom, $urandom, $urandom, $urandom});
         push_seq();
         do_start(model_rk[10]);
         wait_done(0, 1'b1);
         after_done();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
